// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges load and ALU results onto the single register-file write port,
// queueing ALU results that lose arbitration and exporting a pending-destination mask.
module wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [DW-1:0]              alu_data,
    output logic                       alu_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_rd,
    input  logic [DW-1:0]              ld_data,
    output logic                       we,
    output logic [AW-1:0]              wa,
    output logic [DW-1:0]              wn,
    output logic [31:0]                pend_mask,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] mem_rd_q   [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wn_q, wn_d;

    logic acc_alu, alu_keep, ld_sel, fifo_ne, pop, push, alu_direct;

    // Arbitration: load first, then FIFO head, then a bypassing ALU result.
    always_comb begin
        alu_ready  = rst && (cnt_q < CW'(DEPTH));
        acc_alu    = alu_valid && alu_ready;
        alu_keep   = acc_alu && (alu_rd != '0);
        ld_sel     = ld_valid && (ld_rd != '0);
        fifo_ne    = (cnt_q != '0);
        pop        = !ld_sel && fifo_ne;
        alu_direct = !ld_sel && !fifo_ne && alu_keep;
        push       = alu_keep && !alu_direct;

        we_d = 1'b0;
        wa_d = wa_q;
        wn_d = wn_q;
        if (ld_sel) begin
            we_d = 1'b1;
            wa_d = ld_rd;
            wn_d = ld_data;
        end else if (pop) begin
            we_d = 1'b1;
            wa_d = mem_rd_q[rd_ptr_q];
            wn_d = mem_data_q[rd_ptr_q];
        end else if (alu_direct) begin
            we_d = 1'b1;
            wa_d = alu_rd;
            wn_d = alu_data;
        end

        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wn_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wn_q     <= wn_d;
        end
    end

    // Storage needs no reset; validity is tracked by the count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd_q[wr_ptr_q]   <= alu_rd;
            mem_data_q[wr_ptr_q] <= alu_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(PW'(PW'(i) - rd_ptr_q)) < cnt_q) begin
                pend_mask = pend_mask | (32'(1) << mem_rd_q[i]);
            end
        end
    end

    assign we       = we_q;
    assign wa       = wa_q;
    assign wn       = wn_q;
    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wn;
    logic [31:0]   pend_mask;
    logic [CW-1:0] fifo_cnt;

    wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .we(we), .wa(wa), .wn(wn), .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic          r;
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] ad;
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ldd;
        logic          e_rdy;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wn;
        int            e_cnt;
        logic [31:0]   e_pend;
    } vec_t;

    // Reference model: queue of pending ALU results plus the write-port register.
    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wn;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m = m | (32'(1) << mq[i].rd);
        return m;
    endfunction

    task automatic step(input logic r, input logic av, input logic [AW-1:0] ard,
                        input logic [DW-1:0] ad, input logic lv, input logic [AW-1:0] lrd,
                        input logic [DW-1:0] ldd, output logic rdy);
        logic m_ready;
        logic keep;
        ent_t e;
        rst       = r;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldd;
        #1;
        rdy     = alu_ready;
        m_ready = r && (mq.size() < int'(DEPTH));
        chk("alu_ready", 32'(alu_ready), 32'(m_ready));
        if (!r) begin
            mq.delete();
            m_we = 1'b0;
            m_wa = '0;
            m_wn = '0;
        end else begin
            keep = av && m_ready && (ard != '0);
            if (lv && lrd != '0) begin
                m_we = 1'b1; m_wa = lrd; m_wn = ldd;
                if (keep) mq.push_back('{rd: ard, data: ad});
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = 1'b1; m_wa = e.rd; m_wn = e.data;
                if (keep) mq.push_back('{rd: ard, data: ad});
            end else if (keep) begin
                m_we = 1'b1; m_wa = ard; m_wn = ad;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("we", 32'(we), 32'(m_we));
        chk("wa", 32'(wa), 32'(m_wa));
        chk("wn", 32'(wn), 32'(m_wn));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        chk("pend_mask", pend_mask, m_pend());
    endtask

    vec_t          vt[15];
    logic          rdy;
    logic [AW-1:0] wlog[$];
    int            ai;
    int            k;
    logic          lv_r;
    logic          mr;

    initial begin
        checks = 0;
        errors = 0;
        m_we = 1'b0; m_wa = '0; m_wn = '0;

        //          r     av    ard    ad          lv    lrd    ldd          rdy   we    wa     wn          cnt pend
        vt[0]  = '{1'b0, 1'b1, 5'd9, 32'h1,      1'b1, 5'd2,  32'h2,      1'b0, 1'b0, 5'd0, 32'h0,      0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 5'd9, 32'h1,      1'b1, 5'd2,  32'h2,      1'b0, 1'b0, 5'd0, 32'h0,      0, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 5'd9, 32'h1,      1'b1, 5'd2,  32'h2,      1'b0, 1'b0, 5'd0, 32'h0,      0, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd0, 32'h0,      0, 32'h0};
        vt[4]  = '{1'b1, 1'b1, 5'd5, 32'h1234,   1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 5'd5, 32'h1234,   0, 32'h0};
        vt[5]  = '{1'b1, 1'b1, 5'd7, 32'hBBBB,   1'b1, 5'd3,  32'hAAAA,   1'b1, 1'b1, 5'd3, 32'hAAAA,   1, 32'h80};
        vt[6]  = '{1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b1, 5'd7, 32'hBBBB,   0, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd7, 32'hBBBB,   0, 32'h0};
        vt[8]  = '{1'b1, 1'b1, 5'd6, 32'h66,     1'b1, 5'd4,  32'h44,     1'b1, 1'b1, 5'd4, 32'h44,     1, 32'h40};
        vt[9]  = '{1'b1, 1'b1, 5'd0, 32'hFFFF,   1'b1, 5'd0,  32'h5555,   1'b1, 1'b1, 5'd6, 32'h66,     0, 32'h0};
        vt[10] = '{1'b1, 1'b1, 5'd0, 32'hFFFF,   1'b1, 5'd0,  32'h5555,   1'b1, 1'b0, 5'd6, 32'h66,     0, 32'h0};
        vt[11] = '{1'b1, 1'b1, 5'd2, 32'h22,     1'b1, 5'd1,  32'h11,     1'b1, 1'b1, 5'd1, 32'h11,     1, 32'h4};
        vt[12] = '{1'b1, 1'b1, 5'd8, 32'h88,     1'b1, 5'd3,  32'h33,     1'b1, 1'b1, 5'd3, 32'h33,     2, 32'h104};
        vt[13] = '{1'b0, 1'b1, 5'd9, 32'h99,     1'b1, 5'd10, 32'hAA,     1'b0, 1'b0, 5'd0, 32'h0,      0, 32'h0};
        vt[14] = '{1'b1, 1'b0, 5'd0, 32'h0,      1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 5'd0, 32'h0,      0, 32'h0};

        for (int i = 0; i < 15; i++) begin
            step(vt[i].r, vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ldd, rdy);
            chk($sformatf("v%0d_ready", i), 32'(rdy), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vt[i].e_we));
            chk($sformatf("v%0d_wa", i), 32'(wa), 32'(vt[i].e_wa));
            chk($sformatf("v%0d_wn", i), 32'(wn), 32'(vt[i].e_wn));
            chk($sformatf("v%0d_cnt", i), 32'(fifo_cnt), 32'(vt[i].e_cnt));
            chk($sformatf("v%0d_pend", i), pend_mask, vt[i].e_pend);
        end

        // Back-pressure: four loads while the ALU offers rd 10, 11, 12 until accepted.
        ai = 0;
        wlog.delete();
        for (int c = 0; c < 8; c++) begin
            mr = (mq.size() < int'(DEPTH));
            step(1'b1, ai < 3, AW'(10 + ai), DW'(32'hC0 + ai), c < 4, AW'(c + 1),
                 DW'(32'hD0 + c), rdy);
            if (c == 2 || c == 3 || c == 4) chk($sformatf("bp_ready_c%0d", c), 32'(rdy), 32'h0);
            if (c == 0 || c == 1) chk($sformatf("bp_ready_c%0d", c), 32'(rdy), 32'h1);
            if (ai < 3 && mr) ai++;
            if (we && wa >= AW'(10)) wlog.push_back(wa);
        end
        chk("bp_nwrites", 32'(wlog.size()), 32'd3);
        for (int i = 0; i < 3 && i < wlog.size(); i++)
            chk($sformatf("bp_order_%0d", i), 32'(wlog[i]), 32'(10 + i));

        // Fill to DEPTH, then trickle loads so pops and pushes overlap and pointers wrap.
        k = 0;
        for (int c = 0; c < 40; c++) begin
            mr   = (mq.size() < int'(DEPTH));
            lv_r = (c < 30) && (c % 3 != 2);
            step(1'b1, 1'b1, AW'((k % 31) + 1), $urandom, lv_r, AW'((c % 7) + 20),
                 $urandom, rdy);
            chk("wrap_cnt_le_depth", 32'(fifo_cnt <= CW'(DEPTH)), 32'h1);
            if (mr) k++;
        end

        // Randomized traffic, including rd==0 drops and occasional resets.
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 4) == 0) ? AW'(0) : AW'($urandom),
                 $urandom,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 4) == 0) ? AW'(0) : AW'($urandom),
                 $urandom, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
